// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, RV32 opcode and funct7 constants for the issue stage.
//   No ports. The optional mul decode is selected by macro ALU_ISSUE_MUL_EN in alu_ctrl_dec.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND  = 4'd0;
    localparam alu_op_t ALU_XOR  = 4'd1;
    localparam alu_op_t ALU_SLL  = 4'd2;
    localparam alu_op_t ALU_ADD  = 4'd3;
    localparam alu_op_t ALU_SUB  = 4'd4;
    localparam alu_op_t ALU_MUL  = 4'd5;
    localparam alu_op_t ALU_ADDI = 4'd6;
    localparam alu_op_t ALU_SRAI = 4'd7;
    localparam alu_op_t ALU_LSW  = 4'd8;
    localparam alu_op_t ALU_BEQ  = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational RV32 decode to ALU op code and operand-2 select.
//   instr   in  32  instruction word
//   ctrl    out 4   ALU op code (meaningful only when legal)
//   use_imm out 1   operand 2 comes from the immediate rather than rs2
//   legal   out 1   instruction is decodable
//   Macro ALU_ISSUE_MUL_EN enables decode of mul; without it mul is illegal.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  ctrl,
    output logic        use_imm,
    output logic        legal
);

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    // R-type and beq compare/combine two registers; everything else takes imm.
    assign use_imm = !(op == OP_R || op == OP_BRANCH);

    always_comb begin
        ctrl  = ALU_AND;
        legal = 1'b0;
        if (op == OP_R && f7 == F7_BASE) begin
            legal = (f3 == 3'b111) || (f3 == 3'b100) || (f3 == 3'b001) || (f3 == 3'b000);
            ctrl  = (f3 == 3'b111) ? ALU_AND :
                    (f3 == 3'b100) ? ALU_XOR :
                    (f3 == 3'b001) ? ALU_SLL : ALU_ADD;
        end else if (op == OP_R && f7 == F7_ALT && f3 == 3'b000) begin
            legal = 1'b1;
            ctrl  = ALU_SUB;
`ifdef ALU_ISSUE_MUL_EN
        end else if (op == OP_R && f7 == F7_MULDIV && f3 == 3'b000) begin
            legal = 1'b1;
            ctrl  = ALU_MUL;
`endif
        end else if (op == OP_I && f3 == 3'b000) begin
            legal = 1'b1;
            ctrl  = ALU_ADDI;
        end else if (op == OP_I && f3 == 3'b101 && f7 == F7_ALT) begin
            legal = 1'b1;
            ctrl  = ALU_SRAI;
        end else if ((op == OP_LOAD || op == OP_STORE) && f3 == 3'b010) begin
            legal = 1'b1;
            ctrl  = ALU_LSW;
        end else if (op == OP_BRANCH && f3 == 3'b000) begin
            legal = 1'b1;
            ctrl  = ALU_BEQ;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: registers decoded ALU operations toward the ALU with stall/flush and an issue counter.
//   clk_i, rst_i (async active-low)
//   valid_i, instr_i, rs1_data_i, rs2_data_i, imm_i : instruction and operands from ID
//   stall_i, flush_i : hold / squash requests (flush wins)
//   ready_o : accepts valid_i this cycle
//   valid_o, data1_o, data2_o, ALUCtrl_o, illegal_o : registered operation toward the ALU
//   issue_cnt_o : wrapping count of issued legal operations
//   Macro ALU_ISSUE_MUL_EN enables mul decode (inside alu_ctrl_dec).
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] imm_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [3:0]  ALUCtrl_o,
    output logic        illegal_o,
    output logic [15:0] issue_cnt_o
);

    logic [3:0]  dec_ctrl;
    logic        dec_use_imm;
    logic        dec_legal;
    logic        issue;

    logic        valid_q, valid_d;
    logic        illegal_q, illegal_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] d1_q, d1_d;
    logic [31:0] d2_q, d2_d;
    logic [15:0] cnt_q, cnt_d;

    alu_ctrl_dec u_dec (
        .instr   (instr_i),
        .ctrl    (dec_ctrl),
        .use_imm (dec_use_imm),
        .legal   (dec_legal)
    );

    assign issue = valid_i && dec_legal;

    always_comb begin
        valid_d   = valid_q;
        illegal_d = illegal_q;
        ctrl_d    = ctrl_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        cnt_d     = cnt_q;
        if (flush_i) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            ctrl_d    = ALU_AND;
        end else if (!stall_i) begin
            valid_d   = issue;
            illegal_d = valid_i && !dec_legal;
            ctrl_d    = issue ? dec_ctrl : ALU_AND;
            d1_d      = rs1_data_i;
            d2_d      = dec_use_imm ? imm_i : rs2_data_i;
            cnt_d     = issue ? cnt_q + 16'd1 : cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= ALU_AND;
            d1_q      <= '0;
            d2_q      <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            cnt_q     <= cnt_d;
        end
    end

    // ready_o is gated by reset so every output reads 0 while rst_i is low.
    assign ready_o     = rst_i && !stall_i;
    assign valid_o     = valid_q;
    assign illegal_o   = illegal_q;
    assign ALUCtrl_o   = ctrl_q;
    assign data1_o     = d1_q;
    assign data2_o     = d2_q;
    assign issue_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized and directed self-checking bench for alu_issue against a behavioural model.
module tb_alu_issue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [31:0] imm_i = '0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_o, valid_o, illegal_o;
    logic [31:0] data1_o, data2_o;
    logic [3:0]  ALUCtrl_o;
    logic [15:0] issue_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    logic        e_valid = 1'b0, e_ill = 1'b0;
    logic [3:0]  e_ctrl = '0;
    logic [31:0] e_d1 = '0, e_d2 = '0;
    int          e_cnt = 0;
    bit          chk_en = 1'b0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_MUL  = 32'h022081B3;

    alu_issue dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .instr_i(instr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .stall_i(stall_i), .flush_i(flush_i), .ready_o(ready_o), .valid_o(valid_o),
        .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o),
        .illegal_o(illegal_o), .issue_cnt_o(issue_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec decode table: {f7, f3, opcode} patterns, '?' where a field is immediate bits.
    function automatic void ref_dec(input logic [31:0] ins, output logic [3:0] c,
                                    output logic lg, output logic ui);
        logic [16:0] key;
        key = {ins[31:25], ins[14:12], ins[6:0]};
        lg = 1'b1;
        c  = 4'd0;
        casez (key)
            {7'b0000000, 3'b111, 7'b0110011}: c = 4'd0;
            {7'b0000000, 3'b100, 7'b0110011}: c = 4'd1;
            {7'b0000000, 3'b001, 7'b0110011}: c = 4'd2;
            {7'b0000000, 3'b000, 7'b0110011}: c = 4'd3;
            {7'b0100000, 3'b000, 7'b0110011}: c = 4'd4;
`ifdef ALU_ISSUE_MUL_EN
            {7'b0000001, 3'b000, 7'b0110011}: c = 4'd5;
`endif
            {7'b???????, 3'b000, 7'b0010011}: c = 4'd6;
            {7'b0100000, 3'b101, 7'b0010011}: c = 4'd7;
            {7'b???????, 3'b010, 7'b0000011}: c = 4'd8;
            {7'b???????, 3'b010, 7'b0100011}: c = 4'd8;
            {7'b???????, 3'b000, 7'b1100011}: c = 4'd9;
            default: lg = 1'b0;
        endcase
        ui = !(ins[6:0] == 7'b0110011 || ins[6:0] == 7'b1100011);
    endfunction

    task automatic model_edge();
        logic [3:0] c;
        logic lg, ui;
        if (!rst_i) return;
        if (flush_i) begin
            e_valid = 1'b0; e_ill = 1'b0; e_ctrl = 4'd0;
        end else if (!stall_i) begin
            ref_dec(instr_i, c, lg, ui);
            e_valid = valid_i && lg;
            e_ill   = valid_i && !lg;
            e_ctrl  = e_valid ? c : 4'd0;
            e_d1    = rs1_data_i;
            e_d2    = ui ? imm_i : rs2_data_i;
            if (e_valid) e_cnt = (e_cnt + 1) % 65536;
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0; e_ill = 1'b0; e_ctrl = '0; e_d1 = '0; e_d2 = '0; e_cnt = 0;
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("ready_o", 32'(ready_o), 32'(rst_i && !stall_i));
            chk("valid_o", 32'(valid_o), 32'(e_valid));
            chk("illegal_o", 32'(illegal_o), 32'(e_ill));
            chk("ALUCtrl_o", 32'(ALUCtrl_o), 32'(e_ctrl));
            chk("data1_o", data1_o, e_d1);
            if (e_valid) chk("data2_o", data2_o, e_d2);
            chk("issue_cnt_o", 32'(issue_cnt_o), 32'(e_cnt));
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] im, input logic st, input logic fl);
        valid_i = v; instr_i = ins; rs1_data_i = r1; rs2_data_i = r2; imm_i = im;
        stall_i = st; flush_i = fl;
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_ill"}, 32'(illegal_o), 32'd0);
        chk({tag, "_ctrl"}, 32'(ALUCtrl_o), 32'd0);
        chk({tag, "_d1"}, data1_o, 32'd0);
        chk({tag, "_d2"}, data2_o, 32'd0);
        chk({tag, "_cnt"}, 32'(issue_cnt_o), 32'd0);
        chk({tag, "_ready"}, 32'(ready_o), 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_i = 1'b0;
        #1 check_zero(tag);
        model_reset();
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b1;
        @(negedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] base [12];
        logic [31:0] r;
        base = '{32'h00000033, 32'h40000033, 32'h00007033, 32'h00004033, 32'h00001033,
                 32'h02000033, 32'h00000013, 32'h40005013, 32'h00002003, 32'h00002023,
                 32'h00000063, 32'h0};
        r = $urandom;
        return (r[3:0] >= 4'd11) ? $urandom : (base[r[3:0]] | ($urandom & 32'h01FF8F80));
    endfunction

    initial begin
        logic [31:0] alu_res;
        #12 check_zero("reset");
        rst_i = 1'b1;
        @(negedge clk_i);
        #1 chk_en = 1'b1;

        step(1, I_ADD, 32'd5, 32'd7, 32'hDEAD, 0, 0);
        chk("add_valid", 32'(valid_o), 32'd1);
        chk("add_ctrl", 32'(ALUCtrl_o), 32'd3);
        chk("add_d1", data1_o, 32'd5);
        chk("add_d2", data2_o, 32'd7);
        chk("add_cnt", 32'(issue_cnt_o), 32'd1);

        step(1, I_SRAI, 32'h80000000, 32'h1234, 32'h402, 0, 0);
        chk("srai_ctrl", 32'(ALUCtrl_o), 32'd7);
        chk("srai_d2", data2_o, 32'h402);
        alu_res = $signed(data1_o) >>> data2_o[4:0];
        chk("srai_alu", alu_res, 32'hE0000000);

        step(1, I_SW, 32'h100, 32'h55, 32'h8, 0, 0);
        chk("sw_ctrl", 32'(ALUCtrl_o), 32'd8);
        chk("sw_d2", data2_o, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step(1, I_ADD, 32'h1, 32'h2, 32'h3, 1, 0);
            chk("sw_hold_ctrl", 32'(ALUCtrl_o), 32'd8);
            chk("sw_hold_d1", data1_o, 32'h100);
            chk("stall_ready", 32'(ready_o), 32'd0);
        end
        chk("sw_cnt", 32'(issue_cnt_o), 32'd3);

        step(1, I_BEQ, 32'h9, 32'h9, 32'h0, 1, 1);
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_ctrl", 32'(ALUCtrl_o), 32'd0);
        chk("flush_cnt", 32'(issue_cnt_o), 32'd3);

        step(1, I_MUL, 32'd6, 32'd7, 32'd0, 0, 0);
`ifdef ALU_ISSUE_MUL_EN
        chk("mul_ctrl", 32'(ALUCtrl_o), 32'd5);
        chk("mul_valid", 32'(valid_o), 32'd1);
`else
        chk("mul_valid", 32'(valid_o), 32'd0);
        chk("mul_ill", 32'(illegal_o), 32'd1);
        chk("mul_ctrl", 32'(ALUCtrl_o), 32'd0);
`endif

        step(0, 32'hFFFFFFFF, 32'h11, 32'h22, 32'h33, 0, 0);
        chk("bubble_valid", 32'(valid_o), 32'd0);
        chk("bubble_ill", 32'(illegal_o), 32'd0);
        chk("bubble_d1", data1_o, 32'h11);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            if (i == 1500) begin
                step(1, I_ADD, 32'h1, 32'h2, 32'h3, 1, 0);
                pulse_reset("midstall");
                step(1, I_ADD, 32'hA, 32'hB, 32'h0, 0, 0);
                chk("post_rst_valid", 32'(valid_o), 32'd1);
                chk("post_rst_d2", data2_o, 32'hB);
                chk("post_rst_cnt", 32'(issue_cnt_o), 32'd1);
            end
        end

        pulse_reset("wrap_rst");
        for (int i = 0; i < 65535; i++) step(1, I_ADD, i, 32'd1, 32'd0, 0, 0);
        chk("cnt_ffff", 32'(issue_cnt_o), 32'hFFFF);
        step(1, I_ADD, 32'd0, 32'd1, 32'd0, 0, 0);
        chk("cnt_wrap", 32'(issue_cnt_o), 32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
